// File: rtl/equiv_checker_if.sv
// equiv_checker_if: stimulus, response and result signals of the exhaustive equivalence sweep
interface equiv_checker_if #(parameter int N_IN = 5);
    logic start, a, b, c, d, e, m_q, m_a, busy, done, pass, fail_seen;
    logic [N_IN:0] err_cnt;
    logic [N_IN-1:0] first_fail;
    modport master (
        input start, m_q, m_a,
        output a, b, c, d, e, busy, done, pass, fail_seen, err_cnt, first_fail
    );
    modport slave (
        output start, m_q, m_a,
        input a, b, c, d, e, busy, done, pass, fail_seen, err_cnt, first_fail
    );
endinterface

// File: rtl/equiv_checker.sv
// equiv_checker: sweeps all 32 input vectors, compares DUT against golden after a settle window
module equiv_checker #(
    parameter int N_IN = 5,
    parameter int SETTLE_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    equiv_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, COMPARE, DONE} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST = '1;
    localparam logic [N_IN-1:0] VEC_ONE = N_IN'(1);
    localparam logic [N_IN:0] ERR_ONE = (N_IN + 1)'(1);
    state_t state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d, first_q, first_d;
    logic [N_IN:0] err_q, err_d;
    logic [3:0] cnt_q, cnt_d;
    logic fail_q, fail_d, miss;
    assign miss = bus.m_q != bus.m_a;
    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        cnt_d = cnt_q;
        err_d = err_q;
        first_d = first_q;
        fail_d = fail_q;
        case (state_q)
            IDLE, DONE: if (bus.start) begin
                state_d = SETTLE;
                vec_d = '0;
                cnt_d = RELOAD;
                err_d = '0;
                first_d = '0;
                fail_d = 1'b0;
            end
            SETTLE: begin
                state_d = cnt_q == 4'd0 ? COMPARE : SETTLE;
                cnt_d = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            COMPARE: begin
                err_d = miss ? err_q + ERR_ONE : err_q;
                first_d = miss && !fail_q ? vec_q : first_q;
                fail_d = fail_q | miss;
                state_d = vec_q == LAST ? DONE : SETTLE;
                vec_d = vec_q == LAST ? vec_q : vec_q + VEC_ONE;
                cnt_d = RELOAD;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            vec_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            first_q <= '0;
            fail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            first_q <= first_d;
            fail_q <= fail_d;
        end
    assign {bus.a, bus.b, bus.c, bus.d, bus.e} = vec_q;
    assign bus.busy = state_q == SETTLE || state_q == COMPARE;
    assign bus.done = state_q == DONE;
    assign bus.pass = state_q == DONE && err_q == '0;
    assign bus.err_cnt = err_q;
    assign bus.first_fail = first_q;
    assign bus.fail_seen = fail_q;
endmodule
